stack_datapath_v2: RTL and testbench



---
 rtl/stack_datapath_v2_pkg.sv | 45 ++++
 rtl/stack_datapath_v2_if.sv | 21 ++
 rtl/stack_datapath_v2_mem_seq.sv | 62 ++++++
 rtl/stack_datapath_v2.sv | 173 +++++++++++++++++
 tb/tb_stack_datapath_v2.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_datapath_v2_pkg.sv
// rtl/stack_datapath_v2_pkg.sv - shared constants for the stack datapath
package stack_dp_pkg;

  // load_sig bit positions
  localparam int LD_R     = 0;
  localparam int LD_PC    = 1;
  localparam int LD_SP    = 2;
  localparam int LD_F     = 3;
  localparam int LD_T     = 4;
  localparam int LD_MAR   = 5;
  localparam int LD_MDZ   = 6;
  localparam int LD_IR    = 7;
  localparam int LD_SPARE = 8;

  // xfer_sig bit positions (X-bus sources)
  localparam int X_R   = 0;
  localparam int X_PC  = 1;
  localparam int X_SP  = 2;
  localparam int X_MAR = 3;
  localparam int X_MDR = 4;
  localparam int X_L   = 5;

  // ALU opcodes
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_PX   = 3'd6;
  localparam logic [2:0] ALU_PT   = 3'd7;

  // mem_cmd encodings
  localparam logic [1:0] MEM_NONE   = 2'b00;
  localparam logic [1:0] MEM_RD_MDR = 2'b01;
  localparam logic [1:0] MEM_RD_IR  = 2'b10;
  localparam logic [1:0] MEM_WR     = 2'b11;

  // flag bit positions within {V,C,N,Z}
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

endpackage

// File: rtl/stack_datapath_v2_if.sv
// rtl/stack_datapath_v2_if.sv - memory port bundle between datapath and memory
interface stack_datapath_v2_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_req;
  logic          mem_we;
  logic          mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/stack_datapath_v2_mem_seq.sv
// rtl/stack_datapath_v2_mem_seq.sv - IDLE/WAIT memory sequencer driving the memory port
module mem_seq
  import stack_dp_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mem_cmd_i,
  input  logic [DW-1:0]        addr_i,
  input  logic [DW-1:0]        wdata_i,
  stack_datapath_v2_if.master  mem,
  output logic                 busy_o,
  output logic                 cap_mdr_o,
  output logic                 cap_ir_o,
  output logic [DW-1:0]        rdata_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [1:0] cmd_q, cmd_d;

  // next state: accept a command only when idle, leave WAIT on ready
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_IDLE: begin
        if (mem_cmd_i != MEM_NONE) begin
          cmd_d   = mem_cmd_i;
          state_d = S_WAIT;
        end
      end
      default: begin
        if (mem.mem_ready) state_d = S_IDLE;
      end
    endcase
  end

  // state and latched command; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= MEM_NONE;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  assign busy_o        = (state_q == S_WAIT);
  assign mem.mem_req   = busy_o;
  assign mem.mem_we    = busy_o && (cmd_q == MEM_WR);
  assign mem.mem_addr  = addr_i;
  assign mem.mem_wdata = wdata_i;
  assign cap_mdr_o     = busy_o && mem.mem_ready && (cmd_q == MEM_RD_MDR);
  assign cap_ir_o      = busy_o && mem.mem_ready && (cmd_q == MEM_RD_IR);
  assign rdata_o       = mem.mem_rdata;

endmodule

// File: rtl/stack_datapath_v2.sv
// rtl/stack_datapath_v2.sv - stack-machine datapath top; optional guard macro STACK_DATAPATH_STACK_GUARD_EN
module stack_datapath_v2
  import stack_dp_pkg::*;
#(
  parameter int            DW     = 16,
  parameter int            NREG   = 8,
  parameter int            LBL_W  = 12,
  parameter logic [DW-1:0] SP_RST = DW'(16'hFFFF),
  parameter logic [DW-1:0] SP_LO  = '0,
  parameter logic [DW-1:0] SP_HI  = {DW{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8:0]          load_sig,
  input  logic [5:0]          xfer_sig,
  input  logic [2:0]          alop,
  input  logic                sp_inc,
  input  logic                sp_dec,
  input  logic [1:0]          mem_cmd,
  stack_datapath_v2_if.master mem,
  output logic                busy,
  output logic [DW-1:0]       instruction,
  output logic                status,
  output logic                stack_fault
);

  localparam int RIW = $clog2(NREG);

  logic [DW-1:0]  pc_q, sp_q, t_q, mar_q, mdr_q, ir_q;
  logic [3:0]     flg_q;
  logic [DW-1:0]  gpr_q [NREG];

  logic [DW-1:0]  x_bus, z, lbl, rdata, sp_d;
  logic [DW:0]    ext_w;
  logic [3:0]     z_flags;
  logic           cy, ov, sp_upd, sp_bad;
  logic           cap_mdr, cap_ir;
  logic [RIW-1:0] ridx;
  logic [2:0]     ir_cc;
  logic           unused_ld;

  assign ridx      = ir_q[4 +: RIW];
  assign lbl       = {{(DW-LBL_W){ir_q[LBL_W-1]}}, ir_q[LBL_W-1:0]};
  assign ir_cc     = 3'(ir_q >> 12);
  assign unused_ld = load_sig[LD_IR] ^ load_sig[LD_SPARE];

  mem_seq #(.DW(DW)) u_mem_seq (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd_i (mem_cmd),
    .addr_i    (mar_q),
    .wdata_i   (mdr_q),
    .mem       (mem),
    .busy_o    (busy),
    .cap_mdr_o (cap_mdr),
    .cap_ir_o  (cap_ir),
    .rdata_o   (rdata)
  );

  // X bus: wired-OR of every enabled source
  always_comb begin
    x_bus = '0;
    if (xfer_sig[X_R])   x_bus = x_bus | gpr_q[ridx];
    if (xfer_sig[X_PC])  x_bus = x_bus | pc_q;
    if (xfer_sig[X_SP])  x_bus = x_bus | sp_q;
    if (xfer_sig[X_MAR]) x_bus = x_bus | mar_q;
    if (xfer_sig[X_MDR]) x_bus = x_bus | mdr_q;
    if (xfer_sig[X_L])   x_bus = x_bus | lbl;
  end

  // ALU: Z = f(X, T); carry is carry-out on ADD and borrow on SUB
  always_comb begin
    ext_w = '0;
    cy    = 1'b0;
    ov    = 1'b0;
    case (alop)
      ALU_ADD: begin
        ext_w = {1'b0, x_bus} + {1'b0, t_q};
        z     = ext_w[DW-1:0];
        cy    = ext_w[DW];
        ov    = (x_bus[DW-1] == t_q[DW-1]) && (z[DW-1] != x_bus[DW-1]);
      end
      ALU_SUB: begin
        ext_w = {1'b0, x_bus} - {1'b0, t_q};
        z     = ext_w[DW-1:0];
        cy    = ext_w[DW];
        ov    = (x_bus[DW-1] != t_q[DW-1]) && (z[DW-1] != x_bus[DW-1]);
      end
      ALU_AND: z = x_bus & t_q;
      ALU_OR:  z = x_bus | t_q;
      ALU_XOR: z = x_bus ^ t_q;
      ALU_NOT: z = ~x_bus;
      ALU_PX:  z = x_bus;
      default: z = t_q;
    endcase
    z_flags = {ov, cy, z[DW-1], (z == '0)};
  end

  // general-purpose registers, indexed by the IR register field
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else if (load_sig[LD_R]) begin
      gpr_q[ridx] <= z;
    end
  end

  // PC, T, flags, MAR, MDR, IR; MAR/MDR loads are frozen while memory is busy
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      t_q   <= '0;
      flg_q <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
    end else begin
      if (load_sig[LD_PC])             pc_q  <= z;
      if (load_sig[LD_T])              t_q   <= x_bus;
      if (load_sig[LD_F])              flg_q <= z_flags;
      if (load_sig[LD_MAR] && !busy)   mar_q <= z;
      if (cap_mdr)                     mdr_q <= rdata;
      else if (load_sig[LD_MDZ] && !busy) mdr_q <= z;
      if (cap_ir)                      ir_q  <= rdata;
    end
  end

  // SP candidate: a load beats a step; opposing steps cancel
  always_comb begin
    sp_upd = 1'b0;
    sp_d   = sp_q;
    if (load_sig[LD_SP]) begin
      sp_upd = 1'b1;
      sp_d   = z;
    end else if (sp_inc && !sp_dec) begin
      sp_upd = 1'b1;
      sp_d   = sp_q + DW'(1);
    end else if (sp_dec && !sp_inc) begin
      sp_upd = 1'b1;
      sp_d   = sp_q - DW'(1);
    end
  end

`ifdef STACK_DATAPATH_STACK_GUARD_EN
  logic [DW:0] lo_diff, hi_diff;
  logic        fault_q;

  // bound checks done as widened subtractions so either bound may be 0 or all-ones
  assign lo_diff     = {1'b0, sp_d} - {1'b0, SP_LO};
  assign hi_diff     = {1'b0, SP_HI} - {1'b0, sp_d};
  assign sp_bad      = sp_upd && (lo_diff[DW] || hi_diff[DW]);
  assign stack_fault = fault_q;

  // sticky fault flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)       fault_q <= 1'b0;
    else if (sp_bad) fault_q <= 1'b1;
  end
`else
  assign sp_bad      = 1'b0;
  assign stack_fault = 1'b0;
`endif

  // stack pointer; out-of-range updates are dropped when the guard is built in
  always_ff @(posedge clk) begin
    if (reset)                 sp_q <= SP_RST;
    else if (sp_upd && !sp_bad) sp_q <= sp_d;
  end

  assign instruction = ir_q;
  assign status      = flg_q[ir_cc[2:1]] ^ ir_cc[0];

endmodule

// File: tb/tb_stack_datapath_v2.sv
// tb/tb_stack_datapath_v2.sv - self-checking bench for stack_datapath_v2
module tb_stack_datapath_v2;
  import stack_dp_pkg::*;

`ifdef STACK_DATAPATH_STACK_GUARD_EN
  localparam logic [15:0] TB_SP_LO = 16'h0100;
`else
  localparam logic [15:0] TB_SP_LO = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  load_sig = '0;
  logic [5:0]  xfer_sig = '0;
  logic [2:0]  alop = '0;
  logic        sp_inc = 1'b0, sp_dec = 1'b0;
  logic [1:0]  mem_cmd = '0;
  logic        busy, status, stack_fault;
  logic [15:0] instruction;

  int total = 0;
  int bad = 0;

  stack_datapath_v2_if #(.DW(16)) mif ();

  stack_datapath_v2 #(
    .DW(16), .NREG(8), .LBL_W(12), .SP_RST(16'hFFFF), .SP_LO(TB_SP_LO), .SP_HI(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset), .load_sig(load_sig), .xfer_sig(xfer_sig), .alop(alop),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .mem_cmd(mem_cmd), .mem(mif),
    .busy(busy), .instruction(instruction), .status(status), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] t;
    logic [15:0] z;
    logic [3:0]  f;
  } alu_vec_t;

  alu_vec_t tbl [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input int x, input logic [2:0] op, input int ld, input logic inc, input logic dec);
    xfer_sig = 6'(x);
    alop     = op;
    load_sig = 9'(ld);
    sp_inc   = inc;
    sp_dec   = dec;
    tick();
    xfer_sig = '0;
    load_sig = '0;
    sp_inc   = 1'b0;
    sp_dec   = 1'b0;
  endtask

  task automatic mem_op(input logic [1:0] cmd, input logic [15:0] rd, input int waits);
    mem_cmd = cmd;
    tick();
    mem_cmd = MEM_NONE;
    for (int i = 0; i < waits; i++) tick();
    mif.mem_rdata = rd;
    mif.mem_ready = 1'b1;
    tick();
    mif.mem_ready = 1'b0;
  endtask

  task automatic set_mdr(input logic [15:0] v);
    mem_op(MEM_RD_MDR, v, 0);
  endtask

  task automatic set_ir(input logic [15:0] v);
    mem_op(MEM_RD_IR, v, 0);
  endtask

  // route a register through the ALU into MAR so it shows on mem_addr
  task automatic observe(input int src, input logic [2:0] op, output logic [15:0] v);
    step(src, op, 1 << LD_MAR, 1'b0, 1'b0);
    v = mif.mem_addr;
  endtask

  function automatic void alu_model(input int op, input int x, input int t,
                                    output logic [15:0] z, output logic [3:0] f);
    int r, sx, st, sr;
    logic c, v;
    sx = (x >= 32768) ? x - 65536 : x;
    st = (t >= 32768) ? t - 65536 : t;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin r = x + t; c = (r > 65535); sr = sx + st; v = (sr > 32767) || (sr < -32768); end
      1: begin r = x - t; c = (x < t);     sr = sx - st; v = (sr > 32767) || (sr < -32768); end
      2: r = x & t;
      3: r = x | t;
      4: r = x ^ t;
      5: r = ~x;
      6: r = x;
      default: r = t;
    endcase
    z = 16'(r & 65535);
    f = {v, c, z[15], (z == 16'h0000)};
  endfunction

  task automatic run_alu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] t,
                         input logic [15:0] ez, input logic [3:0] ef, input string nm);
    set_mdr(t);
    step(1 << X_MDR, ALU_PX, 1 << LD_T, 1'b0, 1'b0);
    set_mdr(x);
    step(1 << X_MDR, op, (1 << LD_MAR) | (1 << LD_F), 1'b0, 1'b0);
    check({nm, "_z"}, mif.mem_addr, ez);
    for (int cc = 0; cc < 4; cc++) begin
      set_ir(16'(cc << 13));
      check({nm, "_flag"}, status, ef[cc]);
    end
  endtask

  initial begin
    logic [15:0] v, ez;
    logic [3:0]  ef;
    int cnt, ok;
    logic [2:0] rop;
    logic [15:0] rx, rt;

    tbl[0]  = '{ALU_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000};
    tbl[1]  = '{ALU_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101};
    tbl[2]  = '{ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010};
    tbl[3]  = '{ALU_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b0001};
    tbl[4]  = '{ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110};
    tbl[5]  = '{ALU_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000};
    tbl[6]  = '{ALU_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000};
    tbl[7]  = '{ALU_OR,  16'hF000, 16'h000F, 16'hF00F, 4'b0010};
    tbl[8]  = '{ALU_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001};
    tbl[9]  = '{ALU_NOT, 16'h00FF, 16'h1234, 16'hFF00, 4'b0010};
    tbl[10] = '{ALU_PX,  16'h1234, 16'h5555, 16'h1234, 4'b0000};
    tbl[11] = '{ALU_PT,  16'h1111, 16'h8000, 16'h8000, 4'b0010};

    mif.mem_rdata = '0;
    mif.mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_mar", mif.mem_addr, 16'h0000);
    check("rst_mdr", mif.mem_wdata, 16'h0000);
    check("rst_ir", instruction, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_req", mif.mem_req, 1'b0);
    check("rst_we", mif.mem_we, 1'b0);
    check("rst_fault", stack_fault, 1'b0);
    check("rst_status", status, 1'b0);
    observe(1 << X_SP, ALU_PX, v); check("rst_sp", v, 16'hFFFF);
    observe(1 << X_PC, ALU_PX, v); check("rst_pc", v, 16'h0000);
    observe(0, ALU_PT, v);         check("rst_t", v, 16'h0000);
    observe(1 << X_R, ALU_PX, v);  check("rst_r0", v, 16'h0000);

    // table-driven ALU vectors
    for (int i = 0; i < 12; i++) run_alu(tbl[i].op, tbl[i].x, tbl[i].t, tbl[i].z, tbl[i].f, "alu_tbl");

    // randomized ALU against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rx  = 16'($urandom);
      rt  = 16'($urandom);
      alu_model(int'(rop), int'(rx), int'(rt), ez, ef);
      run_alu(rop, rx, rt, ez, ef, "alu_rnd");
    end

    // X bus ORs simultaneous sources
    set_ir(16'h0000);
    set_mdr(16'h0F00);
    step(1 << X_MDR, ALU_PX, 1 << LD_MAR, 1'b0, 1'b0);
    set_mdr(16'h00F0);
    observe((1 << X_MDR) | (1 << X_MAR), ALU_PX, v);
    check("xbus_or", v, 16'h0FF0);

    // R3 = T = 5, SUB sets Z, status from condition field
    set_ir(16'h0030);
    set_mdr(16'h0005);
    step(1 << X_MDR, ALU_PX, (1 << LD_R) | (1 << LD_T), 1'b0, 1'b0);
    observe(1 << X_R, ALU_PX, v); check("r3_val", v, 16'h0005);
    step(1 << X_R, ALU_SUB, 1 << LD_F, 1'b0, 1'b0);
    set_ir(16'h1000); check("status_inv", status, 1'b0);
    set_ir(16'h0000); check("status_z", status, 1'b1);

    // label sign extension into PC
    set_ir(16'h0800);
    step(1 << X_L, ALU_PX, 1 << LD_PC, 1'b0, 1'b0);
    observe(1 << X_PC, ALU_PX, v); check("pc_label", v, 16'hF800);

    // read with 3 wait cycles; MAR load and new command while busy are ignored
    set_mdr(16'h0040);
    step(1 << X_MDR, ALU_PX, 1 << LD_MAR, 1'b0, 1'b0);
    mem_cmd = MEM_RD_MDR;
    check("cmd_cycle_busy", busy, 1'b0);
    tick();
    cnt = 0;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (busy) cnt++;
      if (mif.mem_addr !== 16'h0040 || mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0) ok = 0;
      if (i == 0) begin
        mem_cmd  = MEM_WR;
        xfer_sig = 6'(1 << X_PC);
        alop     = ALU_PX;
        load_sig = 9'(1 << LD_MAR);
      end else begin
        mem_cmd  = MEM_NONE;
        xfer_sig = '0;
        load_sig = '0;
      end
      if (i == 3) begin
        mif.mem_rdata = 16'h1234;
        mif.mem_ready = 1'b1;
      end
      tick();
    end
    mif.mem_ready = 1'b0;
    check("rd_busy_cycles", cnt, 4);
    check("rd_addr_stable", ok, 1);
    check("rd_mdr", mif.mem_wdata, 16'h1234);
    check("rd_req_drop", mif.mem_req, 1'b0);
    tick();
    check("rd_no_queue", busy, 1'b0);

    // write
    set_mdr(16'hABCD);
    mem_cmd = MEM_WR;
    tick();
    mem_cmd = MEM_NONE;
    check("wr_we", mif.mem_we, 1'b1);
    check("wr_data", mif.mem_wdata, 16'hABCD);
    mif.mem_ready = 1'b1;
    tick();
    mif.mem_ready = 1'b0;
    check("wr_we_drop", mif.mem_we, 1'b0);

    // SP load beats a simultaneous step
    set_mdr(16'h0200);
    step(1 << X_MDR, ALU_PX, 1 << LD_SP, 1'b1, 1'b0);
    observe(1 << X_SP, ALU_PX, v); check("sp_load_prio", v, 16'h0200);

`ifdef STACK_DATAPATH_STACK_GUARD_EN
    set_mdr(16'h0100);
    step(1 << X_MDR, ALU_PX, 1 << LD_SP, 1'b0, 1'b0);
    step(0, ALU_PX, 0, 1'b0, 1'b1);
    observe(1 << X_SP, ALU_PX, v); check("guard_sp_hold", v, 16'h0100);
    check("guard_fault", stack_fault, 1'b1);
    step(0, ALU_PX, 0, 1'b1, 1'b0);
    observe(1 << X_SP, ALU_PX, v); check("guard_sp_inc", v, 16'h0101);
    check("guard_fault_sticky", stack_fault, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("guard_fault_clr", stack_fault, 1'b0);
`else
    set_mdr(16'hFFFF);
    step(1 << X_MDR, ALU_PX, 1 << LD_SP, 1'b0, 1'b0);
    step(0, ALU_PX, 0, 1'b1, 1'b0);
    observe(1 << X_SP, ALU_PX, v); check("sp_wrap_inc", v, 16'h0000);
    step(0, ALU_PX, 0, 1'b1, 1'b1);
    observe(1 << X_SP, ALU_PX, v); check("sp_inc_dec", v, 16'h0000);
    step(0, ALU_PX, 0, 1'b0, 1'b1);
    observe(1 << X_SP, ALU_PX, v); check("sp_wrap_dec", v, 16'hFFFF);
    check("no_guard_fault", stack_fault, 1'b0);
`endif

    // reset during WAIT aborts without capture
    mem_cmd = MEM_RD_IR;
    tick();
    mem_cmd = MEM_NONE;
    check("abort_busy_pre", busy, 1'b1);
    reset = 1'b1;
    mif.mem_rdata = 16'hBEEF;
    mif.mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    mif.mem_ready = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_ir", instruction, 16'h0000);
    tick();
    check("abort_req", mif.mem_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
